// File: rtl/ir_bank_buffer.sv
// Double-buffered impulse-response store: loads an IR into the idle set (time-reversed per bank) while the active set is read.
// Latency: 2 cycles from rd_addr_a/rd_addr_b to rd_vals; the load path writes one location per cycle.
// Backpressure: wr_ready is high only while samples are streaming in; zero-fill and the swap wait stall the writer.
module ir_bank_buffer #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 6000,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 13,
    parameter int IDX_W      = 16
) (
    input  logic                                 audio_clk,
    input  logic                                 rst_in,
    input  logic                                 load_start,
    input  logic [IDX_W-1:0]                     load_len,
    input  logic                                 load_abort,
    input  logic                                 wr_valid,
    input  logic signed [DATA_W-1:0]             wr_data,
    output logic                                 wr_ready,
    input  logic                                 frame_strobe,
    input  logic [ADDR_W-1:0]                    rd_addr_a,
    input  logic [ADDR_W-1:0]                    rd_addr_b,
    output logic signed [2*NUM_BANKS*DATA_W-1:0] rd_vals,
    output logic                                 active_set,
    output logic                                 load_busy,
    output logic                                 load_done
);

    localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [IDX_W:0]    TOTAL_X   = (IDX_W+1)'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(BANK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ZERO    = 2'd2,
        S_PENDING = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Load bookkeeping: idx_q counts samples for length compares, bank_q/addr_q
    // walk the time-reversed layout directly so no division is needed.
    logic [IDX_W-1:0]  len_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    // High once PENDING has lasted a full cycle; strobes seen on entry are ignored.
    logic              armed_q;

    logic [IDX_W-1:0]          len_in;
    logic                      last_sample;
    logic                      last_zero;
    logic                      len_full;
    logic                      wr_en;
    logic signed [DATA_W-1:0]  wr_word;
    logic                      swap;

    // Both IR sets, every bank; set index = ~active_set for writes, set_q for reads.
    logic signed [DATA_W-1:0] mem [2][NUM_BANKS][BANK_DEPTH];

    // Read pipeline stage 1: address, range flag and set captured together.
    logic [ADDR_W-1:0] ra_q, rb_q;
    logic              oob_a_q, oob_b_q;
    logic              set_q;
    logic              oob_a, oob_b;

    // Requested length clamped to the capacity of one set.
    always_comb begin
        len_in = load_len;
        if ({1'b0, load_len} > TOTAL_X) begin
            len_in = TOTAL_X[IDX_W-1:0];
        end
    end

    assign last_sample = (idx_q == len_q - 1'b1);
    assign last_zero   = ({1'b0, idx_q} == TOTAL_X - 1'b1);
    assign len_full    = ({1'b0, len_q} == TOTAL_X);

    // FSM state register.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort wins over everything, including a swap strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = (len_in == '0) ? S_ZERO : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_abort) begin
                    state_d = S_IDLE;
                end else if (wr_valid && last_sample) begin
                    state_d = len_full ? S_PENDING : S_ZERO;
                end
            end
            S_ZERO: begin
                if (load_abort) begin
                    state_d = S_IDLE;
                end else if (last_zero) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (load_abort || swap) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake, busy flag, write strobe/data and swap request.
    always_comb begin
        wr_ready  = (state_q == S_LOAD);
        load_busy = (state_q != S_IDLE);
        wr_en     = 1'b0;
        wr_word   = '0;
        swap      = 1'b0;
        case (state_q)
            S_LOAD: begin
                wr_en   = wr_valid && !load_abort;
                wr_word = wr_data;
            end
            S_ZERO: begin
                wr_en = !load_abort;
            end
            S_PENDING: begin
                swap = armed_q && frame_strobe && !load_abort;
            end
            default: ;
        endcase
    end

    // Load counters, set selection and the one-cycle done pulse.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            len_q      <= '0;
            idx_q      <= '0;
            bank_q     <= '0;
            addr_q     <= '0;
            armed_q    <= 1'b0;
            active_set <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && load_start) begin
                len_q  <= len_in;
                idx_q  <= '0;
                bank_q <= '0;
                addr_q <= LAST_ADDR;
            end else if (wr_en) begin
                idx_q <= idx_q + 1'b1;
                if (addr_q == '0) begin
                    addr_q <= LAST_ADDR;
                    bank_q <= bank_q + 1'b1;
                end else begin
                    addr_q <= addr_q - 1'b1;
                end
            end
            armed_q    <= (state_q == S_PENDING);
            active_set <= active_set ^ swap;
            load_done  <= swap;
        end
    end

    // Loader writes only ever target the set that is not being read.
    always_ff @(posedge audio_clk) begin
        if (wr_en) begin
            mem[~active_set][bank_q][addr_q] <= wr_word;
        end
    end

    assign oob_a = ({1'b0, rd_addr_a} >= DEPTH_X);
    assign oob_b = ({1'b0, rd_addr_b} >= DEPTH_X);

    // Read stage 1: register addresses with the set that is active right now.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            ra_q    <= '0;
            rb_q    <= '0;
            oob_a_q <= 1'b0;
            oob_b_q <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            ra_q    <= oob_a ? '0 : rd_addr_a;
            rb_q    <= oob_b ? '0 : rd_addr_b;
            oob_a_q <= oob_a;
            oob_b_q <= oob_b;
            set_q   <= active_set;
        end
    end

    // Read stage 2: fetch both lanes of every bank, zeroing out-of-range lanes.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            rd_vals <= '0;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                rd_vals[(2*k)*DATA_W +: DATA_W]   <= oob_a_q ? '0 : mem[set_q][BANK_W'(k)][ra_q];
                rd_vals[(2*k+1)*DATA_W +: DATA_W] <= oob_b_q ? '0 : mem[set_q][BANK_W'(k)][rb_q];
            end
        end
    end

endmodule

// File: tb/tb_ir_bank_buffer.sv
// Bench for ir_bank_buffer: full/short/aborted/reset loads with random gaps, checked against a sample-indexed model.
// Latency: reads are checked two cycles after the address is applied.
// Backpressure: samples are only counted when wr_valid meets wr_ready at a clock edge.
module tb_ir_bank_buffer;

    localparam int NB    = 4;
    localparam int DEPTH = 6000;
    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int IW    = 16;
    localparam int TOTAL = NB * DEPTH;

    logic                     audio_clk = 1'b0;
    logic                     rst_in;
    logic                     load_start;
    logic [IW-1:0]            load_len;
    logic                     load_abort;
    logic                     wr_valid;
    logic signed [DW-1:0]     wr_data;
    logic                     wr_ready;
    logic                     frame_strobe;
    logic [AW-1:0]            rd_addr_a;
    logic [AW-1:0]            rd_addr_b;
    logic signed [2*NB*DW-1:0] rd_vals;
    logic                     active_set;
    logic                     load_busy;
    logic                     load_done;

    ir_bank_buffer #(
        .NUM_BANKS (NB),
        .BANK_DEPTH(DEPTH),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .IDX_W     (IW)
    ) dut (
        .audio_clk   (audio_clk),
        .rst_in      (rst_in),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_abort  (load_abort),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_strobe(frame_strobe),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_vals     (rd_vals),
        .active_set  (active_set),
        .load_busy   (load_busy),
        .load_done   (load_done)
    );

    always #5 audio_clk = ~audio_clk;

    typedef struct {
        int addr_a;
        int addr_b;
        int lane;
        int exp;
    } rd_vec_t;

    rd_vec_t tbl [13];

    // Reference: each set stored by sample index, with a flag for entries ever written.
    int model [2][TOTAL];
    bit known [2][TOTAL];
    int m_active;
    int load_n;

    int vec_cnt;
    int err_cnt;

    task automatic check(input string nm, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic int lane(input int k);
        logic signed [DW-1:0] v;
        v = rd_vals[k*DW +: DW];
        return int'(v);
    endfunction

    function automatic int exp_val(input int s, input int k, input int a);
        if (a >= DEPTH) return 0;
        return model[s][k*DEPTH + (DEPTH - 1 - a)];
    endfunction

    function automatic bit exp_known(input int s, input int k, input int a);
        if (a >= DEPTH) return 1'b1;
        return known[s][k*DEPTH + (DEPTH - 1 - a)];
    endfunction

    task automatic read_lane(input int a, input int b, input int ln, input int exp, input string tag);
        @(negedge audio_clk);
        rd_addr_a = AW'(a);
        rd_addr_b = AW'(b);
        repeat (2) @(negedge audio_clk);
        check($sformatf("%s_a%0d_b%0d_lane%0d", tag, a, b, ln), lane(ln), exp);
    endtask

    task automatic read_model(input int a, input int b, input string tag);
        int s;
        @(negedge audio_clk);
        rd_addr_a = AW'(a);
        rd_addr_b = AW'(b);
        s = m_active;
        repeat (2) @(negedge audio_clk);
        for (int k = 0; k < NB; k++) begin
            if (exp_known(s, k, a)) check($sformatf("%s_a%0d_bank%0d", tag, a, k), lane(2*k), exp_val(s, k, a));
            if (exp_known(s, k, b)) check($sformatf("%s_b%0d_bank%0d", tag, b, k), lane(2*k+1), exp_val(s, k, b));
        end
    endtask

    // Streams `count` accepted samples into the inactive set.
    // mode 0: value = index+1, mode 1: 0x7FFF, mode 2: random.
    // At accepted-sample number ign_at a stray load_start (len 5) is injected.
    task automatic stream(input int count, input int mode, input int pct, input int ign_at);
        int  sent;
        int  cycles;
        int  s;
        int  d;
        bit  hs;
        bit  ign_done;
        logic signed [DW-1:0] r;
        sent = 0;
        cycles = 0;
        ign_done = 1'b0;
        s = 1 - m_active;
        while (sent < count && cycles < count*20 + 200) begin
            @(negedge audio_clk);
            wr_valid = ($urandom_range(99) < pct);
            case (mode)
                0: d = load_n + 1;
                1: d = 32767;
                default: begin
                    r = DW'($urandom);
                    d = int'(r);
                end
            endcase
            wr_data = DW'(d);
            if (sent == ign_at && !ign_done) begin
                load_start = 1'b1;
                load_len   = IW'(5);
                ign_done   = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            hs = wr_valid && wr_ready;
            @(posedge audio_clk);
            if (hs) begin
                model[s][load_n] = d;
                known[s][load_n] = 1'b1;
                load_n++;
                sent++;
            end
            cycles++;
        end
        load_start = 1'b0;
        check($sformatf("stream_accepted_of_%0d", count), sent, count);
    endtask

    task automatic begin_load(input int len);
        @(negedge audio_clk);
        load_start = 1'b1;
        load_len   = IW'(len);
        @(negedge audio_clk);
        load_start = 1'b0;
        load_n     = 0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vectors read back after the full load of i+1 (set 1 active).
        tbl[0]  = '{5999,    0, 0,     1};
        tbl[1]  = '{5999,    0, 6, 18001};
        tbl[2]  = '{5999,    0, 1,  6000};
        tbl[3]  = '{5999,    0, 7, 24000};
        tbl[4]  = '{   0, 5999, 2, 12000};
        tbl[5]  = '{   0, 5999, 3,  6001};
        tbl[6]  = '{6000,    0, 0,     0};
        tbl[7]  = '{6000,    0, 2,     0};
        tbl[8]  = '{6000,    0, 4,     0};
        tbl[9]  = '{6000,    0, 6,     0};
        tbl[10] = '{6000,    0, 5, 18000};
        tbl[11] = '{3000, 2999, 4, 15000};
        tbl[12] = '{3000, 2999, 5, 15001};

        vec_cnt = 0;
        err_cnt = 0;
        m_active = 0;
        load_n = 0;
        rst_in = 1'b0;
        load_start = 1'b0;
        load_len = '0;
        load_abort = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        frame_strobe = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        // Reset state.
        repeat (2) @(negedge audio_clk);
        check("rst_active_set", int'(active_set), 0);
        check("rst_load_busy", int'(load_busy), 0);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_load_done", int'(load_done), 0);
        for (int k = 0; k < 2*NB; k++) check($sformatf("rst_rd_vals_%0d", k), lane(k), 0);
        rst_in = 1'b1;

        // Full load with random gaps and a stray load_start mid-stream.
        begin_load(TOTAL);
        check("full_busy", int'(load_busy), 1);
        check("full_wr_ready", int'(wr_ready), 1);
        stream(TOTAL, 0, 85, 1000);
        @(negedge audio_clk);
        frame_strobe = 1'b1;
        wr_valid = 1'b1;
        check("pend_wr_ready", int'(wr_ready), 0);
        check("pend_busy", int'(load_busy), 1);
        @(negedge audio_clk);
        frame_strobe = 1'b0;
        check("entry_strobe_no_swap", int'(active_set), 0);
        check("entry_strobe_no_done", int'(load_done), 0);
        repeat (3) begin
            @(negedge audio_clk);
            check("pend_hold_wr_ready", int'(wr_ready), 0);
        end
        @(negedge audio_clk);
        frame_strobe = 1'b1;
        @(negedge audio_clk);
        frame_strobe = 1'b0;
        wr_valid = 1'b0;
        check("swap1_active", int'(active_set), 1);
        check("swap1_done", int'(load_done), 1);
        check("swap1_idle", int'(load_busy), 0);
        m_active = 1;
        @(negedge audio_clk);
        check("swap1_done_pulse", int'(load_done), 0);

        for (int i = 0; i < 13; i++) read_lane(tbl[i].addr_a, tbl[i].addr_b, tbl[i].lane, tbl[i].exp, "tbl");
        for (int i = 0; i < 30; i++) read_model($urandom_range(6100), $urandom_range(6100), "rnd1");

        // Abort at sample 100: back to idle, no swap, strobe afterwards ignored.
        begin_load(500);
        stream(100, 2, 100, -1);
        @(negedge audio_clk);
        load_abort = 1'b1;
        wr_valid = 1'b1;
        @(negedge audio_clk);
        load_abort = 1'b0;
        wr_valid = 1'b0;
        frame_strobe = 1'b1;
        check("abort_busy", int'(load_busy), 0);
        check("abort_wr_ready", int'(wr_ready), 0);
        check("abort_active", int'(active_set), 1);
        @(negedge audio_clk);
        frame_strobe = 1'b0;
        check("abort_no_swap", int'(active_set), 1);
        check("abort_no_done", int'(load_done), 0);

        // Reset at sample 50: everything cleared asynchronously, set 0 active.
        begin_load(300);
        stream(50, 0, 100, -1);
        @(negedge audio_clk);
        wr_valid = 1'b1;
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_active", int'(active_set), 0);
        check("arst_busy", int'(load_busy), 0);
        check("arst_wr_ready", int'(wr_ready), 0);
        check("arst_done", int'(load_done), 0);
        for (int k = 0; k < 2*NB; k++) check($sformatf("arst_rd_vals_%0d", k), lane(k), 0);
        m_active = 0;
        @(negedge audio_clk);
        wr_valid = 1'b0;
        @(negedge audio_clk);
        rst_in = 1'b1;

        // Short load of 10 x 0x7FFF, zero-fill, then swap timing.
        begin_load(10);
        stream(10, 1, 100, -1);
        for (int i = load_n; i < TOTAL; i++) begin
            model[1][i] = 0;
            known[1][i] = 1'b1;
        end
        for (int i = 0; i < TOTAL - 10 - 1; i++) begin
            @(negedge audio_clk);
            wr_valid = 1'b1;
            if (i == 100) begin
                check("zero_wr_ready", int'(wr_ready), 0);
                check("zero_busy", int'(load_busy), 1);
            end
        end
        @(negedge audio_clk);
        frame_strobe = 1'b1;
        @(negedge audio_clk);
        check("zero_last_no_swap", int'(active_set), 0);
        check("pend2_wr_ready", int'(wr_ready), 0);
        @(negedge audio_clk);
        check("entry2_no_swap", int'(active_set), 0);
        check("entry2_no_done", int'(load_done), 0);
        rd_addr_a = AW'(5999);
        @(negedge audio_clk);
        frame_strobe = 1'b0;
        wr_valid = 1'b0;
        check("swap2_active", int'(active_set), 1);
        check("swap2_done", int'(load_done), 1);
        @(negedge audio_clk);
        check("swap2_done_pulse", int'(load_done), 0);
        check("read_before_swap_old_set", lane(0), exp_val(0, 0, 5999));
        @(negedge audio_clk);
        check("read_after_swap_new_set", lane(0), 32767);
        m_active = 1;

        for (int a = 5990; a < DEPTH; a++) read_lane(a, 0, 0, 32767, "short");
        read_lane(5989, 0, 0, 0, "short_zero");
        read_lane(5999, 5999, 2, 0, "short_bank1");
        for (int i = 0; i < 30; i++) read_model($urandom_range(6100), $urandom_range(6100), "rnd2");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ir_bank_buffer.md
IR_BANK_BUFFER -- requirements
Module: ir_bank_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of banks per IR set.
REQ-002 SHALL have parameter BANK_DEPTH, default 6000, words per bank.
REQ-003 SHALL have parameter DATA_W, default 16, signed coefficient width.
REQ-004 SHALL have parameters ADDR_W, default 13, bank address width, and IDX_W, default 16, sample index width; TOTAL = NUM_BANKS*BANK_DEPTH.
REQ-005 SHALL have port audio_clk, input, 1, sole clock.
REQ-006 SHALL have port rst_in, input, 1; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port load_start, input, 1, pulse that starts a load into the inactive set.
REQ-008 SHALL have port load_len, input, IDX_W, number of IR samples to load, sampled on load_start.
REQ-009 SHALL have port load_abort, input, 1, cancels an in-progress load.
REQ-010 SHALL have ports wr_valid (input, 1), wr_data (input signed, DATA_W) and wr_ready (output, 1), the sample-stream handshake.
REQ-011 SHALL have port frame_strobe, input, 1, convolution frame boundary pulse.
REQ-012 SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_W, the two read addresses applied to every bank.
REQ-013 SHALL have port rd_vals, output signed, 2*NUM_BANKS x DATA_W; entry 2k = bank k port A, entry 2k+1 = bank k port B.
REQ-014 SHALL have ports active_set (output, 1), load_busy (output, 1), load_done (output, 1, pulse).

Function
REQ-015 SHALL hold two IR sets (0, 1), each NUM_BANKS banks of BANK_DEPTH x DATA_W; reads come only from active_set; writes go only to the other set.
REQ-016 SHALL map sample index i to bank i/BANK_DEPTH and address BANK_DEPTH-1-(i mod BANK_DEPTH), i.e. time-reversed within a bank, using a bank counter plus a down-counting address counter (no divider).
REQ-017 SHALL implement the FSM IDLE, LOAD, ZERO, PENDING; load_busy = 1 in every state except IDLE.
REQ-018 IDLE -> LOAD on load_start; latch len = min(load_len, TOTAL) and clear the index counter; if len = 0, go directly to ZERO.
REQ-019 LOAD: wr_ready = 1; each wr_valid && wr_ready cycle writes one sample and advances the index; after sample len-1 go to ZERO if len < TOTAL, else to PENDING.
REQ-020 ZERO: wr_ready = 0; write 0 to one location per cycle for indices len..TOTAL-1, then go to PENDING.
REQ-021 PENDING: wr_ready = 0; on the first frame_strobe strictly after entering PENDING, toggle active_set, pulse load_done for 1 cycle, and go to IDLE.
REQ-022 load_start outside IDLE SHALL be ignored; wr_valid outside LOAD SHALL be ignored (no write).
REQ-023 load_abort in LOAD/ZERO/PENDING SHALL return the FSM to IDLE next cycle with no swap and no load_done; it overrides a simultaneous frame_strobe.
REQ-024 Read latency SHALL be 2 cycles from rd_addr to rd_vals; the set-select is pipelined with the address, so data always comes from the set that was active when the address was applied.
REQ-025 rd_addr >= BANK_DEPTH SHALL return 0 on that lane.
REQ-026 Writes to the inactive set SHALL never disturb reads of the active set in the same cycle.

Reset
REQ-027 On rst_in low, SHALL asynchronously set FSM = IDLE, active_set = 0, wr_ready = 0, load_busy = 0, load_done = 0, rd_vals = 0, counters = 0; RAM contents are not cleared.
REQ-028 Reset mid-load SHALL discard the load; set 0 becomes active with whatever contents it holds.

Verification
REQ-029 Full load: load_len=24000, stream i+1 for i=0..23999, then frame_strobe -> active_set=1, load_done one pulse; rd_addr_a=5999 gives rd_vals[0]=1, rd_vals[6]=18001; rd_addr_b=0 gives rd_vals[1]=6000.
REQ-030 Short load: load_len=10, data 0x7FFF; 23990 ZERO cycles, then frame_strobe -> bank0 addresses 5990..5999 = 0x7FFF; bank1 address 5999 = 0.
REQ-031 Back-pressure/idle: wr_valid held high while in ZERO and PENDING -> no writes, wr_ready=0; load_start issued during LOAD -> ignored, len unchanged.
REQ-032 Swap timing: frame_strobe in the cycle of entry to PENDING -> no swap; next strobe -> swap; reads issued 1 cycle before the swap return old-set data.
REQ-033 Abort and reset: load_abort at sample 100 -> IDLE, active_set unchanged; rst_in low at sample 50 -> all outputs 0, active_set=0 asynchronously.
REQ-034 Out-of-range read: rd_addr_a=6000 -> all even rd_vals entries = 0 after 2 cycles.
